// File: rtl/mdu_pkg.sv
// mdu_pkg: HI/LO unit op codes and op-class helper
package mdu_pkg;
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational mult/multu/div/divu producing HI/LO results and a divide-by-zero flag
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div0
);
    logic [2*WIDTH-1:0] sprod, uprod;
    logic [WIDTH-1:0]   bd, abs_a, abs_b, mq, mr, sq, sr, uq, ur;

    // Products via 2W-bit operand extension; low 2W bits of the sign-extended product are exact.
    // Signed divide works on magnitudes: quotient truncates toward zero, remainder follows the dividend.
    // MIN_INT / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself, remainder 0.
    always_comb begin
        sprod  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        uprod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        div0   = (b == '0);
        bd     = div0 ? WIDTH'(1) : b;
        abs_a  = a[WIDTH-1] ? -a : a;
        abs_b  = bd[WIDTH-1] ? -bd : bd;
        mq     = abs_a / abs_b;
        mr     = abs_a % abs_b;
        sq     = (a[WIDTH-1] ^ bd[WIDTH-1]) ? -mq : mq;
        sr     = a[WIDTH-1] ? -mr : mr;
        uq     = a / bd;
        ur     = a % bd;
        hi_res = (op == MDU_MULT)  ? sprod[2*WIDTH-1:WIDTH] :
                 (op == MDU_MULTU) ? uprod[2*WIDTH-1:WIDTH] :
                 (op == MDU_DIV)   ? sr : ur;
        lo_res = (op == MDU_MULT)  ? sprod[WIDTH-1:0] :
                 (op == MDU_MULTU) ? uprod[WIDTH-1:0] :
                 (op == MDU_DIV)   ? sq : uq;
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers and exception-aware write control
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       HILOCtrl,
    input  logic             Req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] Out
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo, hi_res, lo_res;
    logic             pend_wr, div0, accept, move_ok;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (HILOCtrl),
        .a      (A),
        .b      (B),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    // Accept/move gating: a faulting instruction (Req) never starts an op or touches HI/LO.
    always_comb begin
        accept  = Start && !Busy && !Req && is_arith(HILOCtrl);
        move_ok = !Busy && !Req;
        Out     = (HILOCtrl == MDU_MFHI) ? hi : (HILOCtrl == MDU_MFLO) ? lo : '0;
    end

    // Latency counter, pending result and HI/LO; an op in flight finishes even if Req rises later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            Busy    <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept) begin
                cnt     <= is_mult(HILOCtrl) ? CW'(MULT_LAT) : CW'(DIV_LAT);
                Busy    <= 1'b1;
                pend_hi <= hi_res;
                pend_lo <= lo_res;
                pend_wr <= !(div0 && !is_mult(HILOCtrl));
            end else if (cnt == CW'(1)) begin
                cnt     <= '0;
                Busy    <= 1'b0;
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (cnt > CW'(1)) begin
                cnt <= cnt - CW'(1);
            end
            if (move_ok && HILOCtrl == MDU_MTHI) hi <= A;
            if (move_ok && HILOCtrl == MDU_MTLO) lo <= A;
        end
    end
endmodule
